// File: rtl/adder_chk_pkg.sv
// Shared types and widths for the adder response checker.
// Operand, vector-index and counter widths plus the run-state encoding.
package adder_chk_pkg;
   localparam int OP_W     = 4;
   localparam int IDX_W    = 9;
   localparam int CNT_W    = 10;
   localparam int MAP_SIZE = 1 << IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } chk_state_e;
endpackage

// File: rtl/adder_response_checker_if.sv
// Stimulus/response bundle and verdict outputs of the adder response checker.
// master drives the adder vectors and start; slave is the checker.
interface adder_response_checker_if;
   import adder_chk_pkg::*;

   logic             start;
   logic             in_valid;
   logic [OP_W-1:0]  x;
   logic [OP_W-1:0]  y;
   logic             cin;
   logic [OP_W-1:0]  sum;
   logic             cout;

   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] vec_count;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] cov_count;
   logic [IDX_W-1:0] first_fail;
   logic             first_fail_valid;

   modport master (
      output start, in_valid, x, y, cin, sum, cout,
      input  busy, done, pass, vec_count, err_count, cov_count,
             first_fail, first_fail_valid
   );

   modport slave (
      input  start, in_valid, x, y, cin, sum, cout,
      output busy, done, pass, vec_count, err_count, cov_count,
             first_fail, first_fail_valid
   );
endinterface

// File: rtl/adder_ref_model.sv
// Golden 4-bit adder: purely combinational, zero latency, no backpressure.
module adder_ref_model
   import adder_chk_pkg::*;
(
   input  logic [OP_W-1:0] x,
   input  logic [OP_W-1:0] y,
   input  logic            cin,
   output logic [OP_W-1:0] exp_sum,
   output logic            exp_cout
);
   assign {exp_cout, exp_sum} = {1'b0, x} + {1'b0, y} + {{OP_W{1'b0}}, cin};
endmodule

// File: rtl/adder_response_checker.sv
// Scores adder-under-test responses against a golden model; counters lag acceptance by one cycle.
// No backpressure: every in_valid cycle in RUN is consumed, in_valid outside RUN is dropped.
module adder_response_checker
   import adder_chk_pkg::*;
#(
   parameter int NUM_VECTORS = 512
) (
   input  logic                     clk,
   input  logic                     rst_n,
   adder_response_checker_if.slave  bus
);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_VECTORS);

   chk_state_e          state_q, state_d;
   logic [MAP_SIZE-1:0] cov_map_q, cov_map_d;
   logic [CNT_W-1:0]    vec_count_q, vec_count_d;
   logic [CNT_W-1:0]    err_count_q, err_count_d;
   logic [CNT_W-1:0]    cov_count_q, cov_count_d;
   logic [IDX_W-1:0]    first_fail_q, first_fail_d;
   logic                first_fail_valid_q, first_fail_valid_d;
   logic                pass_q, pass_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [OP_W-1:0]     exp_sum;
   logic                exp_cout;
   logic [IDX_W-1:0]    vec_idx;
   logic                accept;
   logic                mismatch;
   logic                begin_run;

   adder_ref_model u_ref (
      .x        (bus.x),
      .y        (bus.y),
      .cin      (bus.cin),
      .exp_sum  (exp_sum),
      .exp_cout (exp_cout)
   );

   assign vec_idx   = {bus.cin, bus.y, bus.x};
   assign accept    = (state_q == ST_RUN) && bus.in_valid;
   assign mismatch  = {bus.cout, bus.sum} != {exp_cout, exp_sum};
   assign begin_run = bus.start && (state_q != ST_RUN);

   always_comb begin
      state_d            = state_q;
      cov_map_d          = cov_map_q;
      vec_count_d        = vec_count_q;
      err_count_d        = err_count_q;
      cov_count_d        = cov_count_q;
      first_fail_d       = first_fail_q;
      first_fail_valid_d = first_fail_valid_q;
      pass_d             = pass_q;

      if (begin_run) begin
         state_d            = ST_RUN;
         cov_map_d          = '0;
         vec_count_d        = '0;
         err_count_d        = '0;
         cov_count_d        = '0;
         first_fail_d       = '0;
         first_fail_valid_d = 1'b0;
         pass_d             = 1'b0;
      end else if (accept) begin
         vec_count_d = vec_count_q + CNT_W'(1);
         if (mismatch) begin
            err_count_d = err_count_q + CNT_W'(1);
            if (!first_fail_valid_q) begin
               first_fail_d       = vec_idx;
               first_fail_valid_d = 1'b1;
            end
         end
         if (!cov_map_q[vec_idx]) begin
            cov_map_d[vec_idx] = 1'b1;
            cov_count_d        = cov_count_q + CNT_W'(1);
         end
         // Verdict includes the final vector, so it is taken from the next-state counters.
         if (vec_count_q == LAST_CNT) begin
            state_d = ST_DONE;
            pass_d  = (err_count_d == '0) && (cov_count_d == FULL_CNT);
         end
      end

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= ST_IDLE;
         cov_map_q          <= '0;
         vec_count_q        <= '0;
         err_count_q        <= '0;
         cov_count_q        <= '0;
         first_fail_q       <= '0;
         first_fail_valid_q <= 1'b0;
         pass_q             <= 1'b0;
         busy_q             <= 1'b0;
         done_q             <= 1'b0;
      end else begin
         state_q            <= state_d;
         cov_map_q          <= cov_map_d;
         vec_count_q        <= vec_count_d;
         err_count_q        <= err_count_d;
         cov_count_q        <= cov_count_d;
         first_fail_q       <= first_fail_d;
         first_fail_valid_q <= first_fail_valid_d;
         pass_q             <= pass_d;
         busy_q             <= busy_d;
         done_q             <= done_d;
      end
   end

   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.pass             = pass_q;
   assign bus.vec_count        = vec_count_q;
   assign bus.err_count        = err_count_q;
   assign bus.cov_count        = cov_count_q;
   assign bus.first_fail       = first_fail_q;
   assign bus.first_fail_valid = first_fail_valid_q;
endmodule

// File: doc/adder_response_checker.md
ADDER_RESPONSE_CHECKER -- requirements
Module: adder_response_checker

Interface
REQ-001 The block SHALL have parameter NUM_VECTORS, default 512, meaning the number of accepted vectors that ends a run (legal range 1..512).
REQ-002 The block SHALL have one clock and one reset: clk, input, 1, rising-edge clock; rst_n, input, 1, asynchronous active-low reset.
REQ-003 start, input, 1, one-cycle pulse that begins a run.
REQ-004 in_valid, input, 1, the x/y/cin/sum/cout bundle is valid this cycle.
REQ-005 x, input, 4, first addend applied to the adder under test.
REQ-006 y, input, 4, second addend.
REQ-007 cin, input, 1, carry in.
REQ-008 sum, input, 4, adder-under-test sum.
REQ-009 cout, input, 1, adder-under-test carry out.
REQ-010 busy, output, 1, high while in RUN.
REQ-011 done, output, 1, high while in DONE.
REQ-012 pass, output, 1, run verdict, meaningful only while done=1.
REQ-013 vec_count, output, 10, vectors accepted in the current run.
REQ-014 err_count, output, 10, mismatching vectors in the current run.
REQ-015 cov_count, output, 10, distinct {cin,y,x} combinations seen in the current run.
REQ-016 first_fail, output, 9, {cin,y,x} of the first mismatching vector.
REQ-017 first_fail_valid, output, 1, first_fail holds a captured vector.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE on the clock edge that accepts vector number NUM_VECTORS.
- DONE->RUN on start.
REQ-019 Entering RUN SHALL clear vec_count, err_count, cov_count, first_fail, first_fail_valid and the coverage bitmap in the same edge.
REQ-020 start while in RUN SHALL be ignored.
REQ-021 A vector SHALL be accepted only when state=RUN and in_valid=1; in_valid in IDLE or DONE SHALL be ignored.
REQ-022 Expected result SHALL be the 5-bit value {exp_cout,exp_sum} = x + y + cin, zero-extended.
REQ-023 A mismatch SHALL be {cout,sum} != {exp_cout,exp_sum}.
REQ-024 On each accepted vector, vec_count SHALL increment by 1.
REQ-025 On each accepted vector, err_count SHALL increment by 1 on mismatch.
REQ-026 On each accepted vector, if bit {cin,y,x} of the 512-bit coverage bitmap is clear, the bit SHALL be set and cov_count SHALL increment by 1; repeat vectors SHALL not change cov_count.
REQ-027 On the first accepted mismatch of a run, first_fail SHALL capture {cin,y,x} and first_fail_valid SHALL go high; later mismatches SHALL not overwrite it.
REQ-028 All outputs SHALL be registered; counters SHALL reflect an accepted vector one cycle after its acceptance edge.
REQ-029 pass SHALL be computed on entry to DONE as err_count==0 and cov_count==NUM_VECTORS, including the final vector, and SHALL hold until the next run starts.
REQ-030 Counters SHALL not wrap: vec_count is bounded by NUM_VECTORS, and err_count and cov_count are bounded by vec_count.
REQ-031 With NUM_VECTORS<512, full coverage is impossible by construction and pass SHALL still use the cov_count==NUM_VECTORS rule.

Reset
REQ-032 rst_n low SHALL asynchronously force state=IDLE and clear every output and the coverage bitmap to 0.
REQ-033 Reset mid-run SHALL discard the run; the block SHALL resume in IDLE on rst_n release.

Structure
REQ-034 A shared package adder_chk_pkg SHALL hold the state enum, the operand width (4), the vector-index width (9) and the counter width (10).
REQ-035 The golden computation SHALL be a combinational sub-module adder_ref_model with inputs x, y, cin and outputs exp_sum, exp_cout.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- Exhaustive sweep: start, then 512 correct vectors in index order -> done=1, pass=1, vec_count=512, err_count=0, cov_count=512.
- Single fault: vector x=4'hF, y=4'h1, cin=0 answered with sum=4'h0, cout=0 -> err_count=1, first_fail=9'h01F, first_fail_valid=1, pass=0.
- Duplicates: 512 correct vectors with index 5 repeated in place of index 6 -> cov_count=511, pass=0.
- in_valid pulsed 3 times in IDLE and 2 times after DONE -> no counter change.
- Reset mid-run: rst_n low after 100 accepted vectors -> all outputs 0 and state IDLE; a fresh start gives vec_count counting from 0.
- Restart: start in DONE after a failing run -> counters and first_fail_valid clear, busy=1 on the next cycle.
